ram_loader: RTL and testbench

Program loader that sits directly upstream of the 16-byte DFF memory and drives its address, data, read (`rin`) and active-low write (`rout_n`) pins. While idle, the CPU bus signals pass straight through to the memory. On `load_start`, the block takes ownership of the memory port and accepts a stream of bytes over a valid/ready handshake. It writes them to consecutive addresses starting at 0, then pulses `load_done` and returns the port to the CPU.

---
 rtl/ram_loader.sv | 84 ++++++++
 tb/tb_ram_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: streams RAM_BYTES bytes into the memory from address 0 while holding the port away from the CPU
module ram_loader #(
   parameter int RAM_BYTES = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic              byte_ready,
   output logic              busy,
   output logic              load_done,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data,
   input  logic              cpu_rin,
   input  logic              cpu_rout_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_rin,
   output logic              mem_rout_n
);
   localparam int CNT_W = ADDR_W + 1;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_data;
   logic              ld_rout_n;
   logic              accept;
   logic              last;
   // a restart in LOAD wins over a byte offered in the same cycle
   assign accept = (state == LOAD) && byte_valid && !load_start;
   assign last   = cnt == CNT_W'(RAM_BYTES - 1);
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   // next state and handshake/status outputs
   always_comb begin
      state_n    = state;
      byte_ready = 1'b0;
      busy       = 1'b1;
      load_done  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (load_start) state_n = LOAD;
         end
         LOAD: begin
            byte_ready = 1'b1;
            if (accept && last) state_n = DONE;
         end
         DONE: begin
            load_done = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // byte counter and registered write strobe; one strobe cycle per accepted byte
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         ld_addr   <= '0;
         ld_data   <= '0;
         ld_rout_n <= 1'b1;
      end else begin
         ld_rout_n <= 1'b1;
         if (load_start && state != DONE) cnt <= '0;
         else if (accept) begin
            ld_addr   <= cnt[ADDR_W-1:0];
            ld_data   <= byte_in;
            ld_rout_n <= 1'b0;
            cnt       <= cnt + 1'b1;
         end
      end
   end
   assign mem_addr   = busy ? ld_addr   : cpu_addr;
   assign mem_data   = busy ? ld_data   : cpu_data;
   assign mem_rin    = busy ? 1'b0      : cpu_rin;
   assign mem_rout_n = busy ? ld_rout_n : cpu_rout_n;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: random-stimulus bench for ram_loader against a session-level model and a behavioural memory
module tb_ram_loader;
   localparam int N = 16;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_in = '0;
   logic       byte_ready, busy, load_done;
   logic [3:0] cpu_addr = '0;
   logic [7:0] cpu_data = '0;
   logic       cpu_rin = 1'b0;
   logic       cpu_rout_n = 1'b1;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_rin, mem_rout_n;
   bit   [7:0] ram [N];
   int         exp_mem [N];
   int         phase = 0;
   int         idx = 0;
   bit         exp_stb = 1'b0;
   int         exp_addr = 0;
   int         exp_data = 0;
   int         n_stb = 0;
   int         n_chk = 0;
   int         n_err = 0;
   int         n0;

   ram_loader dut (
      .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid), .byte_in(byte_in),
      .byte_ready(byte_ready), .busy(busy), .load_done(load_done),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rin(cpu_rin), .cpu_rout_n(cpu_rout_n),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_rin(mem_rin), .mem_rout_n(mem_rout_n)
   );

   always #5 clk = ~clk;

   // the 16-byte memory downstream of the loader
   always @(posedge clk) if (!mem_rout_n) ram[mem_addr] <= mem_data;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // predict the effect of the current inputs at the next edge, take the edge, then compare
   task automatic tick();
      if (busy && !mem_rout_n) n_stb++;
      exp_stb = 1'b0;
      if (phase == 0 && !cpu_rout_n) exp_mem[cpu_addr] = cpu_data;
      if (rst) begin
         phase = 0;
         idx   = 0;
      end else if (phase == 0) begin
         if (load_start) begin
            phase = 1;
            idx   = 0;
         end
      end else if (phase == 2) phase = 0;
      else if (load_start) idx = 0;
      else if (byte_valid) begin
         exp_stb      = 1'b1;
         exp_addr     = idx;
         exp_data     = byte_in;
         exp_mem[idx] = byte_in;
         idx++;
         if (idx == N) phase = 2;
      end
      @(posedge clk);
      #1;
      chk("busy", busy, phase != 0);
      chk("byte_ready", byte_ready, phase == 1);
      chk("load_done", load_done, phase == 2);
      if (phase != 0) begin
         chk("ld_rout_n", mem_rout_n, !exp_stb);
         chk("ld_rin", mem_rin, 0);
         if (exp_stb) begin
            chk("ld_addr", mem_addr, exp_addr);
            chk("ld_data", mem_data, exp_data);
         end
      end else begin
         chk("pt_rout_n", mem_rout_n, cpu_rout_n);
         chk("pt_rin", mem_rin, cpu_rin);
         chk("pt_addr", mem_addr, cpu_addr);
         chk("pt_data", mem_data, cpu_data);
      end
   endtask

   // offer bytes until the model returns to idle: mode 0 back-to-back, 1 every 3rd cycle, 2 random
   task automatic feed(input int mode, input int first, input bit done_start);
      for (int n = 0; n < 400 && phase != 0; n++) begin
         byte_valid = mode == 0 ? 1'b1 : mode == 1 ? (n % 3 == 0) : 1'($urandom_range(0, 1));
         byte_in    = (idx == 0 && first >= 0) ? 8'(first) : mode == 0 ? 8'(8'h10 + idx) : 8'($urandom);
         load_start = done_start && phase == 2;
         tick();
      end
      byte_valid = 1'b0;
      load_start = 1'b0;
      chk("session_end", phase, 0);
   endtask

   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic check_mem();
      for (int i = 0; i < N; i++) chk("mem", ram[i], exp_mem[i]);
   endtask

   initial begin
      cpu_addr = 4'd9;
      cpu_data = 8'h3c;
      tick();
      cpu_rout_n = 1'b0;
      tick();
      chk("rst_mem_addr", mem_addr, 9);
      chk("rst_mem_rout_n", mem_rout_n, 0);
      cpu_rout_n = 1'b1;
      rst = 1'b0;
      tick();
      // stray bytes while idle
      byte_valid = 1'b1;
      n0 = n_stb;
      for (int i = 0; i < 3; i++) begin
         cpu_addr = 4'($urandom);
         byte_in  = 8'($urandom);
         tick();
      end
      byte_valid = 1'b0;
      tick();
      chk("idle_strobes", n_stb - n0, 0);
      // full back-to-back load, with load_start held during DONE
      n0 = n_stb;
      start();
      feed(0, -1, 1'b1);
      tick();
      chk("full_strobes", n_stb - n0, N);
      chk("done_no_restart", busy, 0);
      cpu_addr = 4'd5;
      cpu_rin  = 1'b1;
      #1;
      chk("cpu_read5", mem_rin ? ram[mem_addr] : 0, 8'h15);
      cpu_rin = 1'b0;
      check_mem();
      // gapped valid
      n0 = n_stb;
      start();
      feed(1, -1, 1'b0);
      tick();
      chk("gap_strobes", n_stb - n0, N);
      check_mem();
      // restart after 7 bytes, with a byte offered on the restart cycle
      start();
      byte_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         byte_in = 8'($urandom);
         tick();
      end
      load_start = 1'b1;
      byte_in    = 8'h55;
      tick();
      load_start = 1'b0;
      n0 = n_stb;
      feed(0, 8'haa, 1'b0);
      tick();
      chk("restart_strobes", n_stb - n0, N);
      chk("restart_mem0", ram[0], 8'haa);
      check_mem();
      // reset after 4 bytes
      start();
      byte_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         byte_in = 8'hc0 + 8'(i);
         tick();
      end
      rst     = 1'b1;
      byte_in = 8'hee;
      tick();
      n0 = n_stb;
      rst        = 1'b0;
      byte_valid = 1'b0;
      tick();
      tick();
      chk("rst_no_strobe", n_stb - n0, 0);
      chk("rst_busy", busy, 0);
      for (int i = 0; i < 4; i++) chk("rst_mem", ram[i], 8'hc0 + i);
      check_mem();
      // random sessions
      for (int s = 0; s < 4; s++) begin
         start();
         feed(2, -1, 1'($urandom_range(0, 1)));
         tick();
      end
      check_mem();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
